// File: rtl/regfile_write_ctrl_if.sv
// Write request handshake and the two forwarded read ports of the register-file write controller.
interface regfile_write_ctrl_if #(
  parameter int AW   = 5,
  parameter int XLEN = 32
);
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  modport master (
    output wr_valid, wr_addr, wr_data, ra1, ra2,
    input  wr_ready, rd1, rd2
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, ra1, ra2,
    output wr_ready, rd1, rd2
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Write-side controller for a bit-sliced register file: queues writes, drains one per cycle
// as registered one-hot enables, forwards pending data to two read ports, sequences a clear of r1..r31.
module regfile_write_ctrl #(
  parameter int NREG   = 32,
  parameter int XLEN   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int QDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_ctrl_if.slave  wr,
  input  logic                 clr_req_i,
  input  logic                 hold_i,
  output logic                 busy_o,
  output logic [NREG-1:0]      en_o,
  output logic [XLEN-1:0]      d_o,
  input  logic [NREG*XLEN-1:0] q_bus_i
);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_CLEAR} state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [NREG-1:0] en_q;
  logic [XLEN-1:0] d_q;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   q_addr_q [QDEPTH];
  logic [AW-1:0]   q_addr_d [QDEPTH];
  logic [XLEN-1:0] q_data_q [QDEPTH];
  logic [XLEN-1:0] q_data_d [QDEPTH];
  logic [XLEN-1:0] bank     [NREG];
  logic            push, pop;

  assign wr.wr_ready = (state_q == S_IDLE) && (count_q < CW'(QDEPTH));
  // Writes to r0 complete the handshake but never enter the queue.
  assign push = wr.wr_valid && wr.wr_ready && (wr.wr_addr != '0);
  assign pop  = (state_q != S_CLEAR) && !hold_i && (count_q != '0);

  // Entry 0 is always the head; pop shifts down, push fills the first free slot.
  always_comb begin
    q_addr_d = q_addr_q;
    q_data_d = q_data_q;
    count_d  = count_q;
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        q_addr_d[i] = q_addr_q[i+1];
        q_data_d[i] = q_data_q[i+1];
      end
      count_d = count_q - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (count_d == CW'(i)) begin
          q_addr_d[i] = wr.wr_addr;
          q_data_d[i] = wr.wr_data;
        end
      end
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
      d_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      q_addr_q <= q_addr_d;
      q_data_q <= q_data_d;
      count_q  <= count_d;
      en_q     <= '0;
      if (pop) begin
        en_q <= NREG'(1) << q_addr_q[0];
        d_q  <= q_data_q[0];
      end
      case (state_q)
        S_IDLE: if (clr_req_i) state_q <= S_FLUSH;
        // Wait until the last drained write has reached the banks before clearing.
        S_FLUSH: if (count_q == '0 && en_q == '0) begin
          state_q <= S_CLEAR;
          cnt_q   <= AW'(1);
        end
        S_CLEAR: if (!hold_i) begin
          en_q  <= NREG'(1) << cnt_q;
          d_q   <= '0;
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREG - 1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) bank[r] = q_bus_i[r*XLEN +: XLEN];
  end

  // Priority: r0, youngest queued, older queued, write in flight, bank.
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = bank[ra];
    if (en_q[ra]) v = d_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (CW'(i) < count_q && q_addr_q[i] == ra) v = q_data_q[i];
    end
    if (ra == '0) v = '0;
    return v;
  endfunction

  assign wr.rd1 = fwd(wr.ra1);
  assign wr.rd2 = fwd(wr.ra2);
  assign busy_o = (state_q != S_IDLE);
  assign en_o   = en_q;
  assign d_o    = d_q;
endmodule
